// File: rtl/frame_merge_pkg.sv
// frame_merge_pkg: shared frontend constants.
// Word width, frame field widths, framing constant, counter helper.
package frame_merge_pkg;
  localparam int DATA_BITS   = 128;
  localparam int N_SRC       = 4;
  localparam int CNT_BITS    = 16;

  localparam int CRC_BITS    = 5;
  localparam int MOD_ID_BITS = 4;
  localparam int BLK_ID_BITS = 2;
  localparam int PERIOD_BITS = 48;

  localparam logic [CRC_BITS-1:0] FRAME_SYNC = '1;

  function automatic logic [CNT_BITS-1:0] sat_inc(
    input logic [CNT_BITS-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/frame_merge_if.sv
// frame_merge_if: time-tag, event, output and status bundle.
// master = producer/consumer side, slave = frame_merge.
interface frame_merge_if;
  import frame_merge_pkg::*;

  logic [DATA_BITS-1:0]       tt_data;
  logic                       tt_valid;
  logic                       tt_ready;
  logic                       stall;
  logic [N_SRC*DATA_BITS-1:0] ev_data;
  logic [N_SRC-1:0]           ev_valid;
  logic [N_SRC-1:0]           ev_ready;
  logic [DATA_BITS-1:0]       out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [CNT_BITS-1:0]        events_per_period;

  modport master (
    output tt_data, tt_valid, ev_data, ev_valid, out_ready,
    input  tt_ready, stall, ev_ready, out_data, out_valid,
    input  events_per_period
  );

  modport slave (
    input  tt_data, tt_valid, ev_data, ev_valid, out_ready,
    output tt_ready, stall, ev_ready, out_data, out_valid,
    output events_per_period
  );
endinterface

// File: rtl/frame_merge_rr_arbiter.sv
// rr_arbiter: round-robin arbiter, one-hot grant when i_en.
// Ports: clk, rst, i_en, i_req[N], o_gnt[N].
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [N-1:0]  w_gnt;
  logic          w_hit;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % N);
  endfunction

  // Search starts just after the last winner.
  always_comb begin
    w_gnt = '0;
    w_idx = r_ptr;
    w_hit = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (i_en && !w_hit &&
          i_req[wrap(int'(r_ptr) + k)]) begin
        w_hit = 1'b1;
        w_idx = wrap(int'(r_ptr) + k);
        w_gnt[wrap(int'(r_ptr) + k)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= PW'(N - 1);
    end else if (w_hit) begin
      r_ptr <= w_idx;
    end
  end

  assign o_gnt = w_gnt;
endmodule

// File: rtl/frame_merge.sv
// frame_merge: merges time tags and per-block events into one
// registered stream; clk, rst, bus (frame_merge_if.slave).
module frame_merge
  import frame_merge_pkg::*;
(
  input logic           clk,
  input logic           rst,
  frame_merge_if.slave  bus
);
  logic                 w_ld;
  logic                 w_tt_gnt;
  logic                 w_ev_any;
  logic [N_SRC-1:0]     w_ev_gnt;
  logic [DATA_BITS-1:0] w_ev_word;

  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_stall;
  logic [CNT_BITS-1:0]  r_cnt;
  logic [CNT_BITS-1:0]  r_epp;

  assign w_ld     = ~r_out_valid | bus.out_ready;
  assign w_tt_gnt = ~rst & w_ld & bus.tt_valid;

  // Events only compete when no tag is offered.
  rr_arbiter #(.N(N_SRC)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (~rst & w_ld & ~bus.tt_valid),
    .i_req (bus.ev_valid),
    .o_gnt (w_ev_gnt)
  );

  assign w_ev_any = |w_ev_gnt;

  always_comb begin
    w_ev_word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_ev_gnt[i]) begin
        w_ev_word = w_ev_word |
          bus.ev_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_stall     <= 1'b0;
      r_cnt       <= '0;
      r_epp       <= '0;
    end else begin
      r_stall <= |bus.ev_valid;
      if (w_ld) begin
        r_out_valid <= w_tt_gnt | w_ev_any;
        if (w_tt_gnt) begin
          r_out_data <= bus.tt_data;
        end else if (w_ev_any) begin
          r_out_data <= w_ev_word;
        end
      end
      if (w_tt_gnt) begin
        r_epp <= r_cnt;
        r_cnt <= '0;
      end else if (w_ev_any) begin
        r_cnt <= sat_inc(r_cnt);
      end
    end
  end

  assign bus.tt_ready          = w_tt_gnt;
  assign bus.ev_ready          = w_ev_gnt;
  assign bus.stall             = r_stall;
  assign bus.out_data          = r_out_data;
  assign bus.out_valid         = r_out_valid;
  assign bus.events_per_period = r_epp;
endmodule

// File: tb/tb_frame_merge.sv
// tb_frame_merge: vector table, stall sequence, random traffic
// against a queue-based model, and counter saturation.
module tb_frame_merge;
  logic clk;
  logic rst;

  frame_merge_if bus ();

  frame_merge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [127:0] TT =
    {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_1234};

  typedef struct {
    logic       rst;
    logic       ttv;
    logic [3:0] evv;
    logic       ordy;
    logic       tr;
    logic [3:0] er;
    logic       ov;
    int         code;
    logic       st;
    int         epp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic t, logic [3:0] e, logic o,
    logic xtr, logic [3:0] xer, logic xov,
    int xc, logic xst, int xepp
  );
    vec_t v;
    v.rst = r;   v.ttv = t;  v.evv = e;  v.ordy = o;
    v.tr = xtr;  v.er = xer; v.ov = xov; v.code = xc;
    v.st = xst;  v.epp = xepp;
    return v;
  endfunction

  function automatic logic [127:0] evw(int i);
    return {4{32'hCAFE_0000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] code_word(int c);
    if (c == 4) return TT;
    if (c == 8) return '0;
    return evw(c);
  endfunction

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: rotation order list, holding register.
  int          order[$];
  logic        m_ov;
  logic [127:0] m_od;
  logic        m_st;
  int          m_cnt;
  int          m_epp;

  task automatic m_step(logic r, logic t, logic [127:0] td,
                        logic [3:0] e, logic [511:0] ed,
                        logic o, output logic xtr,
                        output logic [3:0] xer);
    int src;
    logic ld;
    xtr = 1'b0;
    xer = '0;
    src = -1;
    ld  = !m_ov || o;
    if (!r && ld) begin
      if (t) xtr = 1'b1;
      else begin
        foreach (order[k]) begin
          if (src < 0 && e[order[k]]) src = order[k];
        end
        if (src >= 0) xer[src] = 1'b1;
      end
    end
    if (r) begin
      order = {0, 1, 2, 3};
      m_ov = 0; m_od = '0; m_st = 0; m_cnt = 0; m_epp = 0;
    end else begin
      m_st = |e;
      if (ld) begin
        m_ov = xtr || (src >= 0);
        if (xtr) begin
          m_od  = td;
          m_epp = m_cnt;
          m_cnt = 0;
        end else if (src >= 0) begin
          m_od  = ed[src*128 +: 128];
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
          while (order[0] != src)
            order.push_back(order.pop_front());
          order.push_back(order.pop_front());
        end
      end
    end
  endtask

  initial begin
    logic       xtr;
    logic [3:0] xer;
    int         found;
    int         lat;
    logic       r;

    rst           = 1'b1;
    bus.tt_valid  = 1'b0;
    bus.tt_data   = TT;
    bus.ev_valid  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      bus.ev_data[i*128 +: 128] = evw(i);

    tbl.push_back(mk(1,0,4'h0,0, 0,4'h0,0, 8,0, 0));
    tbl.push_back(mk(0,1,4'h0,1, 1,4'h0,1, 4,0, 0));
    tbl.push_back(mk(0,0,4'h0,1, 0,4'h0,0,15,0,-1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,0,4'hF,1, 0,4'(1 << (i % 4)),1,
                       i % 4,1,-1));
    tbl.push_back(mk(0,0,4'h0,1, 0,4'h0,0,15,0,-1));
    tbl.push_back(mk(0,0,4'h4,1, 0,4'h4,1, 2,1,-1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,4'h4,0, 0,4'h0,1, 2,1,-1));
    tbl.push_back(mk(0,0,4'h2,1, 0,4'h2,1, 1,1,-1));
    tbl.push_back(mk(0,1,4'h0,1, 1,4'h0,1, 4,0,10));
    tbl.push_back(mk(0,1,4'h1,1, 1,4'h0,1, 4,1, 0));
    tbl.push_back(mk(0,0,4'h0,1, 0,4'h0,0,15,0,-1));
    tbl.push_back(mk(0,0,4'h1,1, 0,4'h1,1, 0,1,-1));
    tbl.push_back(mk(0,0,4'h0,0, 0,4'h0,1, 0,0,-1));
    tbl.push_back(mk(1,0,4'hA,0, 0,4'h0,0, 8,0, 0));
    tbl.push_back(mk(0,0,4'hA,1, 0,4'h2,1, 1,1,-1));
    tbl.push_back(mk(0,0,4'hA,1, 0,4'h8,1, 3,1,-1));
    tbl.push_back(mk(0,0,4'h0,1, 0,4'h0,0,15,0,-1));
    tbl.push_back(mk(0,0,4'h4,0, 0,4'h4,1, 2,1,-1));
    tbl.push_back(mk(0,1,4'h0,0, 0,4'h0,1, 2,0,-1));
    tbl.push_back(mk(0,1,4'h0,1, 1,4'h0,1, 4,0, 3));

    tick();
    foreach (tbl[n]) begin
      rst           = tbl[n].rst;
      bus.tt_valid  = tbl[n].ttv;
      bus.ev_valid  = tbl[n].evv;
      bus.out_ready = tbl[n].ordy;
      @(negedge clk);
      chk($sformatf("v%0d tt_ready", n), bus.tt_ready, tbl[n].tr);
      chk($sformatf("v%0d ev_ready", n), bus.ev_ready, tbl[n].er);
      tick();
      chk($sformatf("v%0d out_valid", n), bus.out_valid, tbl[n].ov);
      chk($sformatf("v%0d stall", n), bus.stall, tbl[n].st);
      if (tbl[n].code != 15)
        chk($sformatf("v%0d out_data", n), bus.out_data,
            code_word(tbl[n].code));
      if (tbl[n].epp >= 0)
        chk($sformatf("v%0d epp", n), bus.events_per_period,
            128'(tbl[n].epp));
    end

    // Event traffic defers a waiting tag via stall.
    bus.tt_valid  = 1'b0;
    bus.ev_valid  = 4'h2;
    bus.out_ready = 1'b1;
    tick();
    chk("stall_rise", bus.stall, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.tt_valid = ~bus.stall;
      tick();
      chk("tag_deferred", bus.out_data, evw(1));
    end
    bus.ev_valid = 4'h0;
    found = 0;
    lat   = -1;
    for (int i = 0; i < 10 && found == 0; i++) begin
      bus.tt_valid = ~bus.stall;
      tick();
      if (bus.out_valid && bus.out_data == TT) begin
        found = 1;
        lat   = i;
      end
    end
    bus.tt_valid = 1'b0;
    chk("tag_seen", 128'(found), 128'd1);
    chk("tag_cycle", 128'(lat), 128'd1);
    chk("tag_epp", bus.events_per_period, 128'd4);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      r = (c == 0) || ($urandom_range(0, 59) == 0);
      rst           = r;
      bus.tt_valid  = ($urandom_range(0, 7) == 0);
      bus.tt_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.ev_valid  = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 16; j++)
        bus.ev_data[j*32 +: 32] = $urandom;
      m_step(r, bus.tt_valid, bus.tt_data, bus.ev_valid,
             bus.ev_data, bus.out_ready, xtr, xer);
      @(negedge clk);
      chk("rnd tt_ready", bus.tt_ready, xtr);
      chk("rnd ev_ready", bus.ev_ready, xer);
      tick();
      chk("rnd out_valid", bus.out_valid, m_ov);
      if (m_ov) chk("rnd out_data", bus.out_data, m_od);
      chk("rnd stall", bus.stall, m_st);
      chk("rnd epp", bus.events_per_period, 128'(m_epp));
    end

    // Counter saturation.
    for (int i = 0; i < 4; i++)
      bus.ev_data[i*128 +: 128] = evw(i);
    bus.tt_data   = TT;
    rst           = 1'b1;
    bus.tt_valid  = 1'b0;
    bus.ev_valid  = 4'h0;
    bus.out_ready = 1'b1;
    tick();
    rst          = 1'b0;
    bus.ev_valid = 4'hF;
    for (int i = 0; i < 70000; i++) tick();
    bus.ev_valid = 4'h0;
    bus.tt_valid = 1'b1;
    tick();
    chk("sat_epp", bus.events_per_period, 128'd65535);
    tick();
    chk("restart_epp", bus.events_per_period, 128'd0);
    bus.tt_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/frame_merge.md
Name: frame_merge

Overview:
- Sits directly downstream of the time-tag generator in each frontend.
- Merges the 128-bit time-tag word and N per-block single-event words into one registered 128-bit output stream toward the link serializer.
- Drives the time-tag generator's stall input so a time tag is emitted only after events already presented from the previous period have drained.
- Reports events merged per period as a status value.

Parameters:
- DATA_BITS, 128, width of every word (time tag, event, output).
- N_SRC, 4, number of event sources (one per block).
- CNT_BITS, 16, width of the per-period event counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tt_data  in  DATA_BITS  time-tag word.
- tt_valid  in  1  time tag offered; the generator already gates this with stall.
- tt_ready  out  1  time tag accepted this cycle.
- stall  out  1  to the generator; high while event traffic is pending.
- ev_data  in  N_SRC*DATA_BITS  event words; source i occupies bits [i*DATA_BITS +: DATA_BITS].
- ev_valid  in  N_SRC  per-source valid.
- ev_ready  out  N_SRC  per-source accept, one-hot or zero.
- out_data  out  DATA_BITS  merged word (registered).
- out_valid  out  1  merged word valid (registered).
- out_ready  in  1  downstream accept.
- events_per_period  out  CNT_BITS  event count latched at the last time-tag acceptance.

Behaviour:
- Reset values (rst high at a posedge):
  - out_valid=0, out_data=0, stall=0, events_per_period=0.
  - Internal event counter=0.
  - Round-robin pointer=N_SRC-1, so source 0 has priority first.
  - tt_ready and ev_ready are 0 while rst is high.
- Load enable: ld = ~out_valid | out_ready (output-register-only pipeline; no skid).
- Grant, combinational, only when ld=1:
  - tt_valid=1: grant the time tag, tt_ready=1, all ev_ready=0. Time tag has absolute priority.
  - Otherwise grant the first set ev_valid bit, searching from pointer+1 modulo N_SRC. Only that ev_ready bit is 1.
  - The pointer updates to the granted index on an event grant only.
- Transfer: on any grant, out_data <= the granted word and out_valid <= 1.
  - ld=1 with no grant: out_valid <= 0.
  - ld=0: out_data and out_valid hold.
- Handshakes:
  - tt_ready and ev_ready never assert when ld=0.
  - A word held with out_valid=1 and out_ready=0 is stable until accepted.
- Latency: input grant to out_valid is 1 cycle. Full throughput is one word per cycle while out_ready=1.
- Stall: registered, stall <= |ev_valid.
  - It is one cycle late by design. The generator re-checks stall every cycle and its tt_wait persists, so no tag is lost.
  - Under continuous event traffic the tag is deferred until a cycle with no ev_valid.
- Event counter:
  - Increments on each event grant and saturates at 2^CNT_BITS-1 (no wrap).
  - On a time-tag grant: events_per_period <= counter, and counter <= 0.
  - A tag grant and an event grant never coincide.
- Reset mid-operation: a pending output word is discarded, and every input held valid is re-arbitrated from source 0 after reset.
- Simultaneous valid on all sources: grants rotate 0,1,2,3,0…, with no source starved beyond N_SRC-1 grants.

Decomposition:
- Shared frontend package holds:
  - DATA_BITS and the frame field widths: CRC/framing 5, module ID 4, block ID 2, period 48.
  - The framing constant (all-ones).
- Sub-module rr_arbiter (N_SRC requesters, enable input, one-hot grant, internal pointer) keeps the arbitration reusable for the link-side concentrator.

Test Plan:
- After reset, tt_valid=1 with data 0xF…0000_0000_1234 and out_ready=1 -> out_valid=1 next cycle with identical data; tt_ready high for exactly 1 cycle; events_per_period=0.
- ev_valid=4'b1111 held for 8 cycles with out_ready=1 -> ev_ready sequence 1,2,4,8,1,2,4,8; output words are in source order, one per cycle.
- 5 events, then a tag -> events_per_period=5 after the tag grant; the counter restarts. Force 70000 events -> saturates at 65535.
- out_ready=0 for 3 cycles while ev_valid[2]=1 -> out_data/out_valid hold; ev_ready=0 throughout; on out_ready=1 the next word loads in the same cycle.
- ev_valid[1] asserted -> stall=1 the next cycle, and the generator's tt_valid stays 0. After ev_valid deasserts -> stall=0 one cycle later; the tag appears at the output 1 cycle after tt_valid.
- rst pulsed while out_valid=1 and out_ready=0 -> out_valid=0 after reset; with ev_valid=4'b1010 held, the first grant after reset is source 1.
